// File: rtl/mpu_regfile_pkg.sv
// Shared definitions for the MPU register file: write size codes and
// helpers that derive the byte-offset and size-code widths from DATA_W.
// Imported by mpu_regfile and mpu_lane_merge.
package mpu_regfile_pkg;

    // Write field size codes: field width L = 8 << code bits.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } sz_e;

    // Byte-offset width for a register of data_w bits.
    function automatic int sel_w_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Size-code width: must be able to encode codes 0..sel_w.
    function automatic int size_w_of(input int sel_w);
        return $clog2(sel_w + 1);
    endfunction

endpackage

// File: rtl/mpu_regfile_lane_merge.sv
// Purpose : merge a byte-aligned field taken from w_data into an old register word.
// Latency : combinational.
// Backpressure: none.
// Ports   : old (current register word), w_data (source word), w_size (field size code),
//           w_sel (destination byte offset), w_r_sel (source byte offset) -> merged.
module mpu_lane_merge
    import mpu_regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int SEL_W  = sel_w_of(DATA_W),
    parameter int SIZE_W = size_w_of(SEL_W)
) (
    input  logic [DATA_W-1:0] old,
    input  logic [DATA_W-1:0] w_data,
    input  logic [SIZE_W-1:0] w_size,
    input  logic [SEL_W-1:0]  w_sel,
    input  logic [SEL_W-1:0]  w_r_sel,
    output logic [DATA_W-1:0] merged
);

    localparam int NB = DATA_W / 8;

    logic [SEL_W:0]      nbytes;
    logic [NB-1:0]       byte_en;
    logic [DATA_W-1:0]   src;
    logic [DATA_W-1:0]   fmask;
    logic [DATA_W-1:0]   dmask;
    logic [DATA_W-1:0]   dval;

    always_comb begin
        nbytes  = '0;
        byte_en = '0;
        fmask   = '0;
        // Size codes wider than the register clamp to a full-width field.
        if (int'(w_size) > SEL_W) begin
            nbytes = (SEL_W + 1)'(NB);
        end else begin
            nbytes = (SEL_W + 1)'(1) << w_size;
        end
        for (int b = 0; b < NB; b++) begin
            byte_en[b]       = (b < int'(nbytes));
            fmask[b*8 +: 8]  = {8{byte_en[b]}};
        end
        // Logical shifts fill with zeros, so source bits beyond the top of
        // w_data read as 0 and destination bits beyond DATA_W fall off;
        // nothing wraps back to bit 0.
        src    = w_data >> {w_r_sel, 3'b000};
        dmask  = fmask << {w_sel, 3'b000};
        dval   = (src & fmask) << {w_sel, 3'b000};
        merged = (old & ~dmask) | dval;
    end

endmodule

// File: rtl/mpu_regfile.sv
// Purpose : MPU general register file, NRD registered read ports, one partial-width
//           write port and a per-register reservation (pending) scoreboard.
// Latency : reads 1 cycle (r_data/r_busy registered); rsv_ready combinational.
// Backpressure: rsv_valid is only accepted while rsv_ready=1; the requester holds otherwise.
// Ports   : sys_clk, sys_rst (async active-low); r_idx -> r_data, r_busy per port;
//           we/w_idx/w_data/w_size/w_sel/w_r_sel write port; rsv_valid/rsv_idx/rsv_ready.
// Config  : define MPU_REGFILE_FWD_EN to forward same-edge writes/reservations to reads.
module mpu_regfile
    import mpu_regfile_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int DATA_W = 64,
    parameter int NRD    = 4,
    parameter int IDX_W  = $clog2(NREGS),
    parameter int SEL_W  = sel_w_of(DATA_W),
    parameter int SIZE_W = size_w_of(SEL_W)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [NRD*IDX_W-1:0]  r_idx,
    output logic [NRD*DATA_W-1:0] r_data,
    output logic [NRD-1:0]        r_busy,
    input  logic                  we,
    input  logic [IDX_W-1:0]      w_idx,
    input  logic [DATA_W-1:0]     w_data,
    input  logic [SIZE_W-1:0]     w_size,
    input  logic [SEL_W-1:0]      w_sel,
    input  logic [SEL_W-1:0]      w_r_sel,
    input  logic                  rsv_valid,
    input  logic [IDX_W-1:0]      rsv_idx,
    output logic                  rsv_ready
);

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NREGS-1:0]             pending_q, pending_d;
    logic [NRD-1:0][DATA_W-1:0]   r_data_q, r_data_d;
    logic [NRD-1:0]               r_busy_q, r_busy_d;
    logic [DATA_W-1:0]            w_merged;
    logic                         rsv_fire;

    mpu_lane_merge #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .SIZE_W (SIZE_W)
    ) u_merge (
        .old     (regs_q[w_idx]),
        .w_data  (w_data),
        .w_size  (w_size),
        .w_sel   (w_sel),
        .w_r_sel (w_r_sel),
        .merged  (w_merged)
    );

    assign rsv_ready = ~pending_q[rsv_idx];
    assign rsv_fire  = rsv_valid & rsv_ready;

    // Next register and scoreboard state. The reservation is applied after
    // the write-clear so a same-edge write and reservation leave it pending.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (we) begin
            regs_d[w_idx]    = w_merged;
            pending_d[w_idx] = 1'b0;
        end
        if (rsv_fire) begin
            pending_d[rsv_idx] = 1'b1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [IDX_W-1:0] idx;
        assign idx = r_idx[k*IDX_W +: IDX_W];
`ifdef MPU_REGFILE_FWD_EN
        // Read the post-update state so a same-edge write/reservation is visible.
        assign r_data_d[k] = regs_d[idx];
        assign r_busy_d[k] = pending_d[idx];
`else
        assign r_data_d[k] = regs_q[idx];
        assign r_busy_d[k] = pending_q[idx];
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            regs_q    <= '0;
            pending_q <= '0;
            r_data_q  <= '0;
            r_busy_q  <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            r_data_q  <= r_data_d;
            r_busy_q  <= r_busy_d;
        end
    end

    assign r_data = r_data_q;
    assign r_busy = r_busy_q;

endmodule
